// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one 8N1 UART transmitter between two byte sources:
//     source 0 (echo): bytes from the UART receiver, buffered in a small FIFO
//     source 1 (host): valid/ready handshake
//   A round-robin arbiter hands one byte at a time to the transmitter with a
//   single-cycle tx_start, then follows tx_busy until the frame completes.
//   If tx_busy does not rise within BUSY_TIMEOUT cycles the byte is abandoned.
//
// Optional build macro: UART_ECHO_CRLF_EN
//   When defined, an echoed 8'h0D that completes is followed by an inserted
//   8'h0A frame before arbitration resumes.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   rx_data, rx_done  receiver byte and its one-cycle strobe (pushes echo FIFO)
//   host_valid/ready  host handshake; host_data held while valid & !ready
//   tx_busy           transmitter busy flag
//   tx_start, tx_data one-cycle start request and the registered byte
//   echo_level        echo FIFO occupancy
//   overflow          sticky: an rx byte was dropped; overflow_clr clears it
module uart_tx_arbiter #(
  parameter int ECHO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  input  logic                          host_valid,
  input  logic [7:0]                    host_data,
  output logic                          host_ready,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic [$clog2(ECHO_DEPTH):0]   echo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int AW = $clog2(ECHO_DEPTH);
  localparam int CW = $clog2(ECHO_DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
`ifdef UART_ECHO_CRLF_EN
    , S_LF_INSERT
`endif
  } state_t;

  state_t        state;
  logic [7:0]    mem [ECHO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  // last_grant: 0 = echo was granted last, 1 = host was granted last
  logic          last_grant;
`ifdef UART_ECHO_CRLF_EN
  logic          cr_pending;
`endif

  logic arb_ok;
  logic echo_req;
  logic grant_echo;
  logic grant_host;
  logic push;
  logic drop;

  always_comb begin
    echo_req   = (count != '0);
    // A foreign frame (tx_busy high while idle) holds off arbitration.
    arb_ok     = (state == S_IDLE) && !tx_busy && !rst;
    grant_echo = arb_ok && echo_req   && (!host_valid || last_grant);
    grant_host = arb_ok && host_valid && (!echo_req   || !last_grant);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push       = rx_done && ((count != CW'(ECHO_DEPTH)) || grant_echo);
    drop       = rx_done && !push;
  end

  assign host_ready = grant_host;
  assign echo_level = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + AW'(1);
      if (grant_echo) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(grant_echo);
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      last_grant <= 1'b1;
      timer      <= '0;
`ifdef UART_ECHO_CRLF_EN
      cr_pending <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_echo) begin
            tx_data    <= mem[rd_ptr];
            tx_start   <= 1'b1;
            last_grant <= 1'b0;
            timer      <= '0;
            state      <= S_WAIT_BUSY;
`ifdef UART_ECHO_CRLF_EN
            cr_pending <= (mem[rd_ptr] == 8'h0D);
`endif
          end else if (grant_host) begin
            tx_data    <= host_data;
            tx_start   <= 1'b1;
            last_grant <= 1'b1;
            timer      <= '0;
            state      <= S_WAIT_BUSY;
`ifdef UART_ECHO_CRLF_EN
            cr_pending <= 1'b0;
`endif
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
            state <= S_IDLE;
`ifdef UART_ECHO_CRLF_EN
            cr_pending <= 1'b0;
`endif
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
`ifdef UART_ECHO_CRLF_EN
            if (cr_pending) begin
              cr_pending <= 1'b0;
              state      <= S_LF_INSERT;
            end else
`endif
            state <= S_IDLE;
          end
        end
`ifdef UART_ECHO_CRLF_EN
        S_LF_INSERT: begin
          tx_data  <= 8'h0A;
          tx_start <= 1'b1;
          timer    <= '0;
          state    <= S_WAIT_BUSY;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus a randomized
// two-source run checked against per-source byte-order expectations.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int TMO   = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [7:0]              rx_data = '0;
  logic                    rx_done = 1'b0;
  logic                    host_valid = 1'b0;
  logic [7:0]              host_data = '0;
  logic                    host_ready;
  logic                    tx_busy;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic [$clog2(DEPTH):0]  echo_level;
  logic                    overflow;
  logic                    overflow_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.ECHO_DEPTH(DEPTH), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .echo_level(echo_level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after tx_start, stays high a frame.
  logic busy_hold = 1'b0;
  bit   busy_en   = 1'b1;
  bit   rand_len  = 1'b0;
  int   frame_len = 10;
  int   busy_cnt  = 0;
  always @(posedge clk) begin
    if (tx_start && busy_en) busy_cnt <= rand_len ? int'($urandom_range(3, 10)) : frame_len;
    else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_hold | (busy_cnt != 0);

  // Monitor: every transmitted byte with the cycle of its tx_start.
  int         cyc = 0;
  logic [7:0] got[$];
  int         got_cyc[$];
  int         hs_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_start) begin
      got.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
    if (host_valid && host_ready) hs_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; busy_hold = 1'b0; rx_done = 1'b0; host_valid = 1'b0;
    overflow_clr = 1'b0; busy_en = 1'b1; rand_len = 1'b0; frame_len = 10;
    tick(2);
    rst = 1'b0;
    tick(12);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  // Presents a host byte and returns after the edge that accepts it.
  task automatic send_host(input logic [7:0] b);
    bit ok;
    ok = 0;
    host_valid = 1'b1; host_data = b;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (host_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    check("host_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) @(negedge clk);
    check(tag, got.size(), n);
  endtask

  initial begin
    int base, base2, rx_cyc, hs0;
    logic [7:0] exp_q[$];
    logic [7:0] e_q[$];
    logic [7:0] h_q[$];
    logic [7:0] ge[$];
    logic [7:0] gh[$];

    // Reset values
    #1;
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_host_ready", 32'(host_ready), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_echo_level", 32'(echo_level), 0);

    // Single echo with latency
    apply_reset();
    base = got.size();
    rx_cyc = cyc;
    push_rx(8'h41);
    wait_tx("single_wait", base + 1, 50);
    tick(20);
    check("single_count", got.size(), base + 1);
    check("single_data", 32'(got[base]), 32'h41);
    check("single_latency", 32'(got_cyc[base] - rx_cyc), 32'd2);
    check("single_level", 32'(echo_level), 0);

    // Contention: echo wins first after reset, then strict alternation
    apply_reset();
    busy_hold = 1'b1;
    push_rx(8'h31); push_rx(8'h32); push_rx(8'h33);
    base = got.size();
    hs0 = hs_cnt;
    fork
      begin
        send_host(8'h55); send_host(8'h56); send_host(8'h57);
        host_valid = 1'b0;
      end
      begin
        tick(3);
        busy_hold = 1'b0;
      end
    join
    wait_tx("cont_wait", base + 6, 400);
    exp_q = '{8'h31, 8'h55, 8'h32, 8'h56, 8'h33, 8'h57};
    foreach (exp_q[i]) check($sformatf("cont_byte%0d", i), 32'(got[base + i]), 32'(exp_q[i]));
    check("cont_handshakes", hs_cnt - hs0, 3);

    // Overflow, set-dominant clear, drain order
    apply_reset();
    busy_hold = 1'b1;
    base = got.size();
    for (int i = 1; i <= 5; i++) push_rx(8'(i));
    check("ovf_level", 32'(echo_level), DEPTH);
    check("ovf_set", 32'(overflow), 1);
    overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 0);
    rx_data = 8'h06; rx_done = 1'b1; overflow_clr = 1'b1;
    tick(1);
    rx_done = 1'b0; overflow_clr = 1'b0;
    check("ovf_set_dominant", 32'(overflow), 1);
    check("ovf_level_full", 32'(echo_level), DEPTH);
    overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
    check("ovf_clr2", 32'(overflow), 0);
    busy_hold = 1'b0;
    wait_tx("ovf_wait", base + 4, 400);
    tick(20);
    check("ovf_count", got.size(), base + 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_byte%0d", i), 32'(got[base + i]), 32'(i + 1));
    check("ovf_drained", 32'(echo_level), 0);

    // Busy timeout: byte abandoned, next host byte follows after the timeout
    apply_reset();
    busy_en = 1'b0;
    base = got.size();
    hs0 = hs_cnt;
    send_host(8'hAA);
    send_host(8'hBB);
    host_valid = 1'b0;
    wait_tx("tmo_wait", base + 2, 100);
    tick(10);
    check("tmo_count", got.size(), base + 2);
    check("tmo_byte0", 32'(got[base]), 32'hAA);
    check("tmo_byte1", 32'(got[base + 1]), 32'hBB);
    check("tmo_gap", 32'(got_cyc[base + 1] - got_cyc[base]), TMO + 1);
    check("tmo_handshakes", hs_cnt - hs0, 2);
    busy_en = 1'b1;

    // Reset in the middle of a frame with two bytes queued
    apply_reset();
    busy_hold = 1'b1;
    base = got.size();
    push_rx(8'h61); push_rx(8'h62); push_rx(8'h63);
    busy_hold = 1'b0;
    wait_tx("mid_wait", base + 1, 50);
    repeat (3) @(posedge clk);
    #2;
    check("mid_level_before", 32'(echo_level), 2);
    rst = 1'b1;
    #1;
    check("mid_tx_start", 32'(tx_start), 0);
    check("mid_tx_data", 32'(tx_data), 0);
    check("mid_host_ready", 32'(host_ready), 0);
    check("mid_overflow", 32'(overflow), 0);
    check("mid_level", 32'(echo_level), 0);
    tick(2);
    rst = 1'b0;
    base2 = got.size();
    tick(30);
    check("mid_quiet", got.size(), base2);
    push_rx(8'h77);
    wait_tx("mid_new_wait", base2 + 1, 50);
    check("mid_new_byte", 32'(got[base2]), 32'h77);

    // CR echo with a pending host byte
    apply_reset();
    busy_hold = 1'b1;
    push_rx(8'h0D);
    base = got.size();
    fork
      begin send_host(8'h99); host_valid = 1'b0; end
      begin tick(3); busy_hold = 1'b0; end
    join
`ifdef UART_ECHO_CRLF_EN
    exp_q = '{8'h0D, 8'h0A, 8'h99};
`else
    exp_q = '{8'h0D, 8'h99};
`endif
    wait_tx("crlf_wait", base + exp_q.size(), 200);
    tick(30);
    check("crlf_count", got.size(), base + exp_q.size());
    foreach (exp_q[i]) check($sformatf("crlf_byte%0d", i), 32'(got[base + i]), 32'(exp_q[i]));

    // Randomized: echo bytes 00..7F, host bytes 80..FF; each stream keeps order
    apply_reset();
    rand_len = 1'b1;
    e_q.delete(); h_q.delete();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 127));
      if (b == 8'h0D) b = 8'h0E;
      e_q.push_back(b);
      h_q.push_back(8'($urandom_range(128, 255)));
    end
    base = got.size();
    fork
      begin
        foreach (e_q[i]) begin
          tick(30 + int'($urandom_range(0, 10)));
          push_rx(e_q[i]);
        end
      end
      begin
        foreach (h_q[i]) begin
          tick(int'($urandom_range(0, 15)));
          send_host(h_q[i]);
          host_valid = 1'b0;
        end
      end
    join
    wait_tx("rand_wait", base + 24, 3000);
    tick(20);
    ge.delete(); gh.delete();
    for (int i = base; i < got.size(); i++) begin
      if (got[i][7]) gh.push_back(got[i]);
      else           ge.push_back(got[i]);
    end
    check("rand_echo_count", ge.size(), e_q.size());
    check("rand_host_count", gh.size(), h_q.size());
    foreach (e_q[i]) check($sformatf("rand_echo%0d", i), 32'(ge[i]), 32'(e_q[i]));
    foreach (h_q[i]) check($sformatf("rand_host%0d", i), 32'(gh[i]), 32'(h_q[i]));
    check("rand_overflow", 32'(overflow), 0);
    check("rand_level", 32'(echo_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one 8N1 UART transmitter between two byte sources. Source 0 is the loopback echo path: bytes from the UART receiver's rx_data/rx_done, buffered in a small FIFO. Source 1 is a local host using a valid/ready handshake. A round-robin arbiter picks one byte at a time and drives the transmitter via a single-cycle tx_start pulse, then tracks tx_busy until the frame completes.

Parameters:
ECHO_DEPTH, 4, echo FIFO depth in bytes; power of two, minimum 2
BUSY_TIMEOUT, 4, clk cycles to wait for tx_busy to rise after tx_start before abandoning the frame

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_data  input  8  received byte, valid when rx_done=1
rx_done  input  1  one-cycle pulse from receiver; pushes rx_data into echo FIFO
host_valid  input  1  host byte available
host_data  input  8  host byte, held stable while host_valid=1 and host_ready=0
host_ready  output  1  host byte accepted this cycle when host_valid & host_ready
tx_busy  input  1  transmitter busy flag
tx_start  output  1  one-cycle request to transmitter
tx_data  output  8  byte to transmit; registered, stable from tx_start until frame end
echo_level  output  $clog2(ECHO_DEPTH)+1  current echo FIFO occupancy
overflow  output  1  sticky flag: an rx byte was dropped because the FIFO was full
overflow_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (async) values:
  - state=S_IDLE; FIFO empty, echo_level=0.
  - tx_start=0, tx_data=8'h00, host_ready=0, overflow=0.
  - last_grant=1, so the echo source wins the first contention.
- Echo FIFO: circular buffer with read/write pointers and a count.
  - rx_done pushes when count<ECHO_DEPTH, or when count==ECHO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - A pop happens only on an echo grant in S_IDLE. Pointers wrap modulo ECHO_DEPTH.
- overflow: set-dominant. A drop and overflow_clr in the same cycle leaves overflow=1.
- FSM states:
  - S_IDLE: requests are echo_req = (count!=0) and host_req = host_valid.
    - If both are requesting, grant the source not equal to last_grant.
    - If only one is requesting, grant it. If neither, stay in S_IDLE.
    - On grant: load tx_data from the FIFO head (pop) or from host_data (host_ready=1 this cycle), assert tx_start=1 for one cycle, update last_grant, then go to S_WAIT_BUSY.
    - host_ready is combinational: (state==S_IDLE) & host_valid & grant==host. It is 0 in all other states.
  - S_WAIT_BUSY: count cycles.
    - tx_busy=1 moves to S_WAIT_DONE.
    - If BUSY_TIMEOUT cycles elapse with tx_busy=0, return to S_IDLE; the byte is lost, with no retry.
  - S_WAIT_DONE: tx_busy=0 moves to S_IDLE. The earliest next tx_start is the cycle after the return to S_IDLE.
- Latency: a byte pushed while the controller is idle reaches the FIFO on the rx_done edge. The echo grant and tx_start occur on the next cycle, so there are 2 clk from rx_done to tx_start.
- tx_busy=1 while in S_IDLE, from a foreign start, is ignored: arbitration waits until tx_busy=0.
- Reset mid-frame returns to S_IDLE at once. tx_start is never left asserted. FIFO contents are discarded.
- rx_done during S_WAIT_* still pushes: the FIFO fills independently of the FSM.

Optional Feature:
UART_ECHO_CRLF_EN
- Defined: when an echo-granted byte equal to 8'h0D completes (tx_busy falls in S_WAIT_DONE), the FSM enters S_LF_INSERT instead of S_IDLE.
  - S_LF_INSERT issues tx_start with tx_data=8'h0A on the next cycle without arbitration or a FIFO pop, then proceeds through S_WAIT_BUSY and S_WAIT_DONE.
  - last_grant stays on echo.
  - A timeout on the CR frame skips the LF insertion.
- Undefined: no S_LF_INSERT state; 8'h0D is echoed like any other byte.

Test Plan:
- Single echo: rx_done with rx_data=8'h41; tx_busy model rises 1 cycle after tx_start and stays high 10 cycles -> exactly one tx_start, tx_data=8'h41, 2 clk after rx_done; echo_level returns to 0.
- Contention: FIFO holds 8'h31 and host_valid=1 with host_data=8'h55 after reset -> sequence 8'h31, then 8'h55 (host_ready pulses once), then alternates while both keep requesting.
- Overflow: 5 rx_done pulses (8'h01..8'h05) while tx_busy is held high, ECHO_DEPTH=4 -> echo_level=4, overflow=1, bytes transmitted 01,02,03,04; overflow_clr -> overflow=0.
- Timeout: tx_busy tied 0, host sends 8'hAA -> tx_start once, FSM returns to S_IDLE after 4 cycles, the next host byte is accepted.
- Reset mid-frame: assert rst during S_WAIT_DONE with 2 bytes queued -> all outputs at reset values immediately, no tx_start after release until new input.
- CRLF (macro defined): echo 8'h0D -> transmitted 8'h0D then 8'h0A, with a pending host byte sent only after the 8'h0A frame; undefined: only 8'h0D.
